// File: rtl/sync_fifo_pkg.sv
// Shared types and defaults for the flagged synchronous FIFO.
// The optional first-word-fall-through read mode is selected with the
// SYNC_FIFO_FWFT_EN macro (see sync_fifo_flags.sv).
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Per-cycle operation, encoded as {wr_ok, rd_ok}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  // Map the accepted write/read strobes onto the operation enum.
  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    return fifo_op_e'({wr_ok, rd_ok});
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flags: synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the pointers.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one word per accepted write.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port is combinational so the head word is always presented.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Read mode: define SYNC_FIFO_FWFT_EN for first-word-fall-through,
// otherwise rd_data is registered one cycle after an accepted read.
//
// Handshake: wr_en/rd_en are requests. A write is accepted (wr_ok) only
// when the registered state is not full, a read (rd_ok) only when it is
// not empty; both decisions use the count as it stood before the edge,
// so a simultaneous read never makes room for a write in the same cycle.
// A rejected request has no effect on data, only on the sticky error flags.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;
  fifo_op_e         op;
  logic [WIDTH-1:0] mem_rd_data;

  // Status decodes of the registered occupancy.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign op    = decode_op(wr_ok, rd_ok);

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd_data)
  );

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - CW'(1);
      end
      OP_WR_RD: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  // Head word is presented continuously; rd_en acknowledges and pops it.
  assign rd_data  = mem_rd_data;
  assign rd_valid = !empty;

`else

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Registered read: capture the head on an accepted read, else hold data.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_ok) begin
      rd_data_d  = mem_rd_data;
      rd_valid_d = 1'b1;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`endif

  // Structural invariants of the occupancy counter.
  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
  a_full_empty  : assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule : sync_fifo_flags

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO that generalises the basic single-clock FIFO with programmable almost-full/almost-empty thresholds, an occupancy count output, sticky overflow/underflow error flags and a compile-time first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and serves as the standard buffering element for datapath blocks and verification benches.

## Interface
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write word.
- rd_en  input  1  read request (FWFT: acknowledge of head word).
- clr_err  input  1  clears overflow/underflow.
- rd_data  output  WIDTH  read word.
- rd_valid  output  1  rd_data holds a valid word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

## Operation
- wr_ok = wr_en && !full; rd_ok = rd_en && !empty; both evaluated on the registered count.
- wr_ok: mem[wr_ptr] ← wr_data, wr_ptr+1. rd_ok: rd_ptr+1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- count: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
- Write while full is rejected even with a simultaneous read; read while empty is rejected even with a simultaneous write.
- full/empty/almost_* are combinational decodes of the registered count.
- overflow set on wr_en && full; underflow set on rd_en && empty; held until clr_err or rst. If clr_err and a new error occur in the same cycle, set wins.
- Standard mode: on rd_ok, rd_data ← mem[rd_ptr] and rd_valid=1 next cycle; otherwise rd_valid=0 and rd_data holds its last value.
- Reset: pointers, count, rd_data=0, rd_valid=0, overflow=0, underflow=0; so empty=1, full=0, almost_empty=1, almost_full=0 (if AF_LEVEL>0). Memory contents are not cleared. Reset mid-operation discards all stored words.

## Timing
- Write-to-empty deassert: 1 edge (wr_ok at edge N → empty=0 after N).
- Standard read latency: rd_en at edge N → rd_data/rd_valid valid after N, held one cycle.
- FWFT read latency: word written at edge N visible on rd_data after N.
- Flag and count updates occur on the same edge as the accepted operation.
- Back-to-back reads/writes every cycle at full throughput.

## Configuration
- SYNC_FIFO_FWFT_EN defined: rd_data = mem[rd_ptr] continuously, rd_valid = !empty, rd_en pops the head; rd_data undefined-but-stable while empty.
- Undefined: standard registered-read mode as above.

## Structure
- Package sync_fifo_pkg: enum fifo_op_e {OP_IDLE, OP_WR, OP_RD, OP_WR_RD} decoding {wr_ok, rd_ok}; default constants for WIDTH, DEPTH.
- Sub-module sync_fifo_mem: DEPTH×WIDTH array, synchronous write, asynchronous read; top holds pointers, count, flags and output register.

## Test plan
- Reset, then write 16 words 0x00..0x0F (DEPTH=16) → count=16, full=1, almost_full asserted at count=14, overflow=0.
- 17th write while full → rejected, overflow=1 sticky; clr_err → overflow=0.
- Read 16 words (standard mode) → rd_data 0x00..0x0F one cycle after each rd_en, empty=1 after last; extra read → underflow=1.
- Simultaneous wr_en/rd_en at count=5 for 40 cycles → count stays 5, data order preserved across pointer wrap.
- rd_en+wr_en while empty → write accepted, read rejected, count=1, underflow=1; wr_en+rd_en while full → read accepted, write rejected, count=15.
- SYNC_FIFO_FWFT_EN: write 0xA5 at edge N → rd_data=0xA5, rd_valid=1 after N; assert rst mid-stream → count=0, empty=1, rd_valid=0 next edge.
